// File: rtl/obj_kin_pkg.sv
// Shared definitions for the object velocity engine: dir/flag bit layout
// and the sweep FSM state type.
package obj_kin_pkg;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;
    localparam int   EN_BIT  = 1;
    localparam int   DIR_BIT = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/vel_axis_step.sv
// One-axis sign-magnitude velocity step: saturating add when the acceleration
// agrees with the current direction, exact zero-crossing when it opposes it.
module vel_axis_step
    import obj_kin_pkg::*;
#(
    parameter int W    = 10,
    parameter int VMAX = 1023
) (
    input  logic [W-1:0] v,
    input  logic [1:0]   d,
    input  logic [W-1:0] a,
    input  logic [1:0]   ad,
    output logic [W-1:0] v_nxt,
    output logic [1:0]   d_nxt
);

    localparam logic [W:0] VMAX_E = (W+1)'(VMAX);

    logic [W:0] sum_s;

    // Next magnitude and dir/flag for the selected object on this axis
    always_comb begin
        sum_s = {1'b0, v} + {1'b0, a};
        v_nxt = v;
        d_nxt = d;
        if (ad[EN_BIT]) begin
            d_nxt[EN_BIT] = 1'b1;
            if (d[DIR_BIT] == ad[DIR_BIT]) begin
                v_nxt = (sum_s > VMAX_E) ? VMAX_E[W-1:0] : sum_s[W-1:0];
            end else if (v > a) begin
                v_nxt = v - a;
            end else begin
                // Reversal: the residue carries on in the acceleration's direction
                v_nxt          = a - v;
                d_nxt[DIR_BIT] = ad[DIR_BIT];
            end
        end else begin
            v_nxt = v;
            d_nxt = d;
        end
    end

endmodule

// File: rtl/object_velocity_engine.sv
// Time-multiplexed velocity integrator: one moveclk tick sweeps all objects,
// applying the latched global acceleration to one object per cycle.
module object_velocity_engine
    import obj_kin_pkg::*;
#(
    parameter  int NUM_OBJ = 8,
    parameter  int VXW     = 10,
    parameter  int VYW     = 9,
    parameter  int VMAX_X  = 1023,
    parameter  int VMAX_Y  = 511,
    localparam int IDXW    = $clog2(NUM_OBJ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            moveclk,
    input  logic [VXW-1:0]  ax,
    input  logic [VYW-1:0]  ay,
    input  logic [1:0]      adx,
    input  logic [1:0]      ady,
    input  logic            load_en,
    input  logic [IDXW-1:0] load_idx,
    input  logic [VXW-1:0]  load_vx,
    input  logic [VYW-1:0]  load_vy,
    input  logic [1:0]      load_vdx,
    input  logic [1:0]      load_vdy,
    input  logic [IDXW-1:0] rd_idx,
    output logic [VXW-1:0]  rd_vx,
    output logic [VYW-1:0]  rd_vy,
    output logic [1:0]      rd_vdx,
    output logic [1:0]      rd_vdy,
    output logic            busy,
    output logic            done,
    output logic            tick_lost
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_OBJ - 1);

    sweep_state_t    state_r;
    logic [IDXW-1:0] cnt_r;
    logic [VXW-1:0]  ax_r;
    logic [VYW-1:0]  ay_r;
    logic [1:0]      adx_r;
    logic [1:0]      ady_r;

    logic [VXW-1:0]  vx_r  [NUM_OBJ];
    logic [VYW-1:0]  vy_r  [NUM_OBJ];
    logic [1:0]      vdx_r [NUM_OBJ];
    logic [1:0]      vdy_r [NUM_OBJ];

    logic [VXW-1:0]  vx_nxt_s;
    logic [VYW-1:0]  vy_nxt_s;
    logic [1:0]      vdx_nxt_s;
    logic [1:0]      vdy_nxt_s;

    vel_axis_step #(.W(VXW), .VMAX(VMAX_X)) u_step_x (
        .v     (vx_r[cnt_r]),
        .d     (vdx_r[cnt_r]),
        .a     (ax_r),
        .ad    (adx_r),
        .v_nxt (vx_nxt_s),
        .d_nxt (vdx_nxt_s)
    );

    vel_axis_step #(.W(VYW), .VMAX(VMAX_Y)) u_step_y (
        .v     (vy_r[cnt_r]),
        .d     (vdy_r[cnt_r]),
        .a     (ay_r),
        .ad    (ady_r),
        .v_nxt (vy_nxt_s),
        .d_nxt (vdy_nxt_s)
    );

    // Sweep sequencer with registered busy/done/tick_lost
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            ax_r      <= '0;
            ay_r      <= '0;
            adx_r     <= 2'b00;
            ady_r     <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            tick_lost <= 1'b0;
        end else begin
            done      <= 1'b0;
            tick_lost <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (moveclk) begin
                        ax_r    <= ax;
                        ay_r    <= ay;
                        adx_r   <= adx;
                        ady_r   <= ady;
                        cnt_r   <= '0;
                        state_r <= ST_RUN;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    tick_lost <= moveclk;
                    if (cnt_r == LAST_IDX) begin
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + IDXW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Object register file: sweep write, overriding load, registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                vx_r[i]  <= '0;
                vy_r[i]  <= '0;
                vdx_r[i] <= 2'b00;
                vdy_r[i] <= 2'b00;
            end
            rd_vx  <= '0;
            rd_vy  <= '0;
            rd_vdx <= 2'b00;
            rd_vdy <= 2'b00;
        end else begin
            if (state_r == ST_RUN) begin
                vx_r[cnt_r]  <= vx_nxt_s;
                vy_r[cnt_r]  <= vy_nxt_s;
                vdx_r[cnt_r] <= vdx_nxt_s;
                vdy_r[cnt_r] <= vdy_nxt_s;
            end
            // Placed after the sweep write so a colliding load takes precedence
            if (load_en) begin
                vx_r[load_idx]  <= load_vx;
                vy_r[load_idx]  <= load_vy;
                vdx_r[load_idx] <= load_vdx;
                vdy_r[load_idx] <= load_vdy;
            end
            rd_vx  <= vx_r[rd_idx];
            rd_vy  <= vy_r[rd_idx];
            rd_vdx <= vdx_r[rd_idx];
            rd_vdy <= vdy_r[rd_idx];
        end
    end

endmodule

// File: tb/tb_object_velocity_engine.sv
// Bench for object_velocity_engine: cycle-level behavioural model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_object_velocity_engine;

    localparam int NUM_OBJ = 8;
    localparam int VXW     = 10;
    localparam int VYW     = 9;
    localparam int VMAX_X  = 1023;
    localparam int VMAX_Y  = 511;
    localparam int IDXW    = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            moveclk;
    logic [VXW-1:0]  ax;
    logic [VYW-1:0]  ay;
    logic [1:0]      adx, ady;
    logic            load_en;
    logic [IDXW-1:0] load_idx;
    logic [VXW-1:0]  load_vx;
    logic [VYW-1:0]  load_vy;
    logic [1:0]      load_vdx, load_vdy;
    logic [IDXW-1:0] rd_idx;
    logic [VXW-1:0]  rd_vx;
    logic [VYW-1:0]  rd_vy;
    logic [1:0]      rd_vdx, rd_vdy;
    logic            busy, done, tick_lost;

    object_velocity_engine #(
        .NUM_OBJ(NUM_OBJ), .VXW(VXW), .VYW(VYW), .VMAX_X(VMAX_X), .VMAX_Y(VMAX_Y)
    ) dut (
        .clk(clk), .rst(rst), .moveclk(moveclk),
        .ax(ax), .ay(ay), .adx(adx), .ady(ady),
        .load_en(load_en), .load_idx(load_idx),
        .load_vx(load_vx), .load_vy(load_vy),
        .load_vdx(load_vdx), .load_vdy(load_vdy),
        .rd_idx(rd_idx),
        .rd_vx(rd_vx), .rd_vy(rd_vy), .rd_vdx(rd_vdx), .rd_vdy(rd_vdy),
        .busy(busy), .done(done), .tick_lost(tick_lost)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_vx  [NUM_OBJ];
    int         m_vy  [NUM_OBJ];
    logic [1:0] m_vdx [NUM_OBJ];
    logic [1:0] m_vdy [NUM_OBJ];
    int         e_vx, e_vy;
    logic [1:0] e_vdx, e_vdy;
    bit         e_busy, e_done, e_lost;
    bit         sweeping = 1'b0;
    int         next_obj = 0;
    int         s_ax, s_ay;
    logic [1:0] s_adx, s_ady;
    bit         model_ok = 1'b0;

    function automatic void axis(input int v, input logic [1:0] d, input int a,
                                 input logic [1:0] ad, input int vmax,
                                 output int vo, output logic [1:0] dn);
        vo = v;
        dn = d;
        if (ad[1]) begin
            dn[1] = 1'b1;
            if (d[0] == ad[0])      vo = (v + a > vmax) ? vmax : v + a;
            else if (v > a)         vo = v - a;
            else begin              vo = a - v; dn[0] = ad[0]; end
        end
    endfunction

    always @(posedge clk) begin
        int         k, nv;
        logic [1:0] nd;
        if (rst) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                m_vx[i] = 0; m_vy[i] = 0; m_vdx[i] = 2'b00; m_vdy[i] = 2'b00;
            end
            e_vx = 0; e_vy = 0; e_vdx = 2'b00; e_vdy = 2'b00;
            e_busy = 1'b0; e_done = 1'b0; e_lost = 1'b0; sweeping = 1'b0;
        end else begin
            e_vx = m_vx[rd_idx]; e_vy = m_vy[rd_idx];
            e_vdx = m_vdx[rd_idx]; e_vdy = m_vdy[rd_idx];
            e_done = 1'b0;
            e_lost = 1'b0;
            if (sweeping) begin
                k = next_obj;
                axis(m_vx[k], m_vdx[k], s_ax, s_adx, VMAX_X, nv, nd);
                m_vx[k] = nv; m_vdx[k] = nd;
                axis(m_vy[k], m_vdy[k], s_ay, s_ady, VMAX_Y, nv, nd);
                m_vy[k] = nv; m_vdy[k] = nd;
                next_obj++;
                if (next_obj == NUM_OBJ) begin sweeping = 1'b0; e_done = 1'b1; end
                if (moveclk) e_lost = 1'b1;
            end else if (moveclk) begin
                sweeping = 1'b1; next_obj = 0;
                s_ax = int'(ax); s_ay = int'(ay); s_adx = adx; s_ady = ady;
            end
            if (load_en) begin
                m_vx[load_idx] = int'(load_vx); m_vy[load_idx] = int'(load_vy);
                m_vdx[load_idx] = load_vdx;     m_vdy[load_idx] = load_vdy;
            end
            e_busy = sweeping;
        end
        model_ok = 1'b1;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (model_ok) begin
            chk("cyc_rd_vx",  int'(rd_vx),  e_vx);
            chk("cyc_rd_vy",  int'(rd_vy),  e_vy);
            chk("cyc_rd_vdx", int'(rd_vdx), int'(e_vdx));
            chk("cyc_rd_vdy", int'(rd_vdy), int'(e_vdy));
            chk("cyc_busy",   int'(busy),   int'(e_busy));
            chk("cyc_done",   int'(done),   int'(e_done));
            chk("cyc_lost",   int'(tick_lost), int'(e_lost));
        end
    end

    // ---------------- directed stimulus ----------------
    int         r_vx, r_vy;
    logic [1:0] r_vdx, r_vdy;

    task automatic tick();
        moveclk = 1'b1;
        @(negedge clk);
        moveclk = 1'b0;
    endtask

    task automatic load(input int idx, input int vx, input logic [1:0] vdx,
                        input int vy, input logic [1:0] vdy);
        load_en = 1'b1; load_idx = IDXW'(idx);
        load_vx = VXW'(vx); load_vdx = vdx; load_vy = VYW'(vy); load_vdy = vdy;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic read_obj(input int idx);
        rd_idx = IDXW'(idx);
        @(negedge clk);
        r_vx = int'(rd_vx); r_vy = int'(rd_vy); r_vdx = rd_vdx; r_vdy = rd_vdy;
    endtask

    task automatic wait_done(input string nm);
        int seen;
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk(nm, seen, 1);
    endtask

    initial begin
        int nb, nd, nl;
        rst = 1'b1; moveclk = 1'b0; ax = '0; ay = '0; adx = 2'b00; ady = 2'b00;
        load_en = 1'b0; load_idx = '0; load_vx = '0; load_vy = '0;
        load_vdx = 2'b00; load_vdy = 2'b00; rd_idx = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd_vx", int'(rd_vx), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1) same-direction add
        load(0, 10, 2'b01, 0, 2'b00);
        adx = 2'b11; ax = 10'd3;
        tick();
        wait_done("t1_done");
        read_obj(0);
        chk("t1_vx", r_vx, 13);
        chk("t1_vdx", int'(r_vdx), 3);

        // 2) exact crossing then growth in the new direction
        load(1, 5, 2'b11, 0, 2'b00);
        adx = 2'b10; ax = 10'd8;
        tick();
        wait_done("t2_done_a");
        read_obj(1);
        chk("t2_vx_cross", r_vx, 3);
        chk("t2_vdx_cross", int'(r_vdx), 2);
        tick();
        wait_done("t2_done_b");
        read_obj(1);
        chk("t2_vx_grow", r_vx, 11);

        // 3) y saturation
        load(2, 0, 2'b00, 509, 2'b11);
        adx = 2'b00; ady = 2'b11; ay = 9'd4;
        tick();
        wait_done("t3_done_a");
        read_obj(2);
        chk("t3_vy_sat", r_vy, 511);
        tick();
        wait_done("t3_done_b");
        read_obj(2);
        chk("t3_vy_sat2", r_vy, 511);
        chk("t3_vdy", int'(r_vdy), 3);

        // 4) busy length, single done, lost tick mid-sweep
        ady = 2'b00;
        tick();
        nb = 0; nd = 0; nl = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) nb++;
            if (done) nd++;
            if (tick_lost) nl++;
            moveclk = (i == 2);
            @(negedge clk);
        end
        moveclk = 1'b0;
        chk("t4_busy_cycles", nb, 8);
        chk("t4_done_pulses", nd, 1);
        chk("t4_lost_pulses", nl, 1);

        // 5) load collides with the sweep write of object 4
        adx = 2'b11; ax = 10'd3; ady = 2'b11; ay = 9'd3;
        tick();
        for (int i = 0; i < 4; i++) @(negedge clk);
        load(4, 100, 2'b00, 50, 2'b01);
        wait_done("t5_done");
        read_obj(4);
        chk("t5_vx", r_vx, 100);
        chk("t5_vdx", int'(r_vdx), 0);
        chk("t5_vy", r_vy, 50);
        chk("t5_vdy", int'(r_vdy), 1);

        // 6) reset mid-sweep, then a disabled sweep leaves values alone
        tick();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", int'(busy), 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("t6_no_done", nd, 0);
        read_obj(4);
        chk("t6_vx_clr", r_vx, 0);
        chk("t6_vdy_clr", int'(r_vdy), 0);
        load(3, 7, 2'b01, 9, 2'b10);
        adx = 2'b00; ady = 2'b00;
        tick();
        wait_done("t6_done");
        read_obj(3);
        chk("t6_vx_keep", r_vx, 7);
        chk("t6_vdx_keep", int'(r_vdx), 1);
        chk("t6_vy_keep", r_vy, 9);
        read_obj(0);
        chk("t6_obj0", r_vx, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
